axis_downsizer: RTL and testbench



---
 rtl/axis_downsizer_pkg.sv | 22 ++
 rtl/axis_downsizer.sv | 102 ++++++++++
 tb/tb_axis_downsizer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_downsizer_pkg.sv
// Shared definitions for the AXI-Stream downsizer: default word width,
// counter-width helper and the FSM state encoding.
package axis_downsizer_pkg;

  localparam int unsigned WORD_W_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  // Bits needed to index n chunks (at least 1 so a RATIO=1 build still has a counter).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/axis_downsizer.sv
// AXI-Stream width downsizer: each accepted S_BUS_W beat is held and replayed
// as up to RATIO M_BUS_W chunks, LSB chunk first, stopping at the highest
// chunk that carries any keep bit.
// Ports: clk/rst (async active-high), s_valid/s_ready/s_data/s_keep/s_last
// slave side, m_valid/m_ready/m_data/m_keep/m_last master side.
module axis_downsizer
  import axis_downsizer_pkg::*;
#(
  parameter int unsigned WORD_W  = WORD_W_DEF,
  parameter int unsigned S_BUS_W = 32,
  parameter int unsigned M_BUS_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [S_BUS_W-1:0]          s_data,
  input  logic [S_BUS_W/WORD_W-1:0]   s_keep,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [M_BUS_W-1:0]          m_data,
  output logic [M_BUS_W/WORD_W-1:0]   m_keep,
  output logic                        m_last
);

  localparam int unsigned S_WORDS = S_BUS_W / WORD_W;
  localparam int unsigned M_WORDS = M_BUS_W / WORD_W;
  localparam int unsigned RATIO   = S_BUS_W / M_BUS_W;
  localparam int unsigned CW      = cnt_width(RATIO);

  state_t               state, state_nxt;
  logic [S_BUS_W-1:0]   hold_data;
  logic [S_WORDS-1:0]   hold_keep;
  logic                 hold_last;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        fin;
  logic [CW-1:0]        s_fin;
  logic                 at_fin;
  logic                 accept;
  logic                 capture;

  // Highest chunk of the incoming beat with any keep bit set.
  always_comb begin
    s_fin = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (|s_keep[i*M_WORDS +: M_WORDS]) s_fin = CW'(i);
    end
  end

  assign at_fin  = (cnt == fin);
  assign s_ready = (state == EMPTY) || (m_ready && at_fin);
  assign accept  = s_valid && s_ready;
  // An empty non-final beat is consumed without being held.
  assign capture = accept && ((|s_keep) || s_last);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (capture) state_nxt = SEND;
      SEND:  if (m_ready && at_fin && !capture) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_keep <= '0;
      hold_last <= 1'b0;
      cnt       <= '0;
      fin       <= '0;
    end else if (capture) begin
      hold_data <= s_data;
      hold_keep <= s_keep;
      hold_last <= s_last;
      cnt       <= '0;
      fin       <= s_fin;
    end else if ((state == SEND) && m_ready && !at_fin) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    m_valid = (state == SEND);
    m_last  = (state == SEND) && hold_last && at_fin;
    m_data  = '0;
    m_keep  = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (cnt == CW'(i)) begin
        m_data = hold_data[i*M_BUS_W +: M_BUS_W];
        m_keep = hold_keep[i*M_WORDS +: M_WORDS];
      end
    end
  end

endmodule

// File: tb/tb_axis_downsizer.sv
module tb_axis_downsizer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [0:0]  m_keep;
  logic        m_last;

  int unsigned total;
  int unsigned bad;

  logic [7:0]  exp_w[$];
  bit          exp_l[$];
  logic [31:0] bd[$];
  logic [3:0]  bk[$];
  bit          bl[$];

  axis_downsizer #(
    .WORD_W (8),
    .S_BUS_W(32),
    .M_BUS_W(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_keep (s_keep),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_keep (m_keep),
    .m_last (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chunk(input string tag, input logic [7:0] d, input logic k, input logic l);
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_data"},  m_data, d);
    check({tag, "_keep"},  m_keep, k);
    check({tag, "_last"},  m_last, l);
  endtask

  initial begin
    int unsigned n, cyc, pkts, bi;
    logic [31:0] d;
    logic [3:0]  k;
    logic [7:0]  ew;
    bit          el;

    total = 0;
    bad = 0;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_keep = '0;
    s_last = 1'b0;
    m_ready = 1'b0;

    // reset state
    tick(); tick();
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last",  m_last, 0);
    check("rst_m_keep",  m_keep, 0);
    check("rst_m_data",  m_data, 0);
    check("rst_s_ready", s_ready, 1);
    rst = 1'b0;
    tick();

    // full beat, 4 chunks back-to-back
    s_valid = 1; s_data = 32'h44332211; s_keep = 4'b1111; s_last = 1; m_ready = 1;
    #1 check("full_s_ready", s_ready, 1);
    tick(); s_valid = 0; #1;
    chunk("full_c0", 8'h11, 1, 0);
    tick(); #1 chunk("full_c1", 8'h22, 1, 0);
    tick(); #1 chunk("full_c2", 8'h33, 1, 0);
    tick(); #1 chunk("full_c3", 8'h44, 1, 1);
    check("full_c3_s_ready", s_ready, 1);
    tick(); #1 check("full_idle", m_valid, 0);

    // partial beat keep=0011
    s_valid = 1; s_data = 32'h44332211; s_keep = 4'b0011; s_last = 1;
    tick(); s_valid = 0; #1;
    chunk("part_c0", 8'h11, 1, 0);
    check("part_c0_s_ready", s_ready, 0);
    tick(); #1 chunk("part_c1", 8'h22, 1, 1);
    check("part_c1_s_ready", s_ready, 1);
    tick(); #1 check("part_idle", m_valid, 0);

    // stall holds outputs, then back-to-back beats without a bubble
    s_valid = 1; s_data = 32'hDDCCBBAA; s_keep = 4'b1111; s_last = 0; m_ready = 0;
    tick(); s_valid = 0; #1;
    chunk("stall_a", 8'hAA, 1, 0);
    check("stall_s_ready", s_ready, 0);
    tick(); #1 chunk("stall_b", 8'hAA, 1, 0);
    m_ready = 1;
    tick(); #1 chunk("b2b_c1", 8'hBB, 1, 0);
    tick(); #1 chunk("b2b_c2", 8'hCC, 1, 0);
    tick();
    s_valid = 1; s_data = 32'h04030201; s_keep = 4'b1111; s_last = 1;
    #1 chunk("b2b_c3", 8'hDD, 1, 0);
    check("b2b_s_ready", s_ready, 1);
    tick(); s_valid = 0; #1;
    chunk("b2b_n0", 8'h01, 1, 0);
    tick(); #1 chunk("b2b_n1", 8'h02, 1, 0);
    tick(); #1 chunk("b2b_n2", 8'h03, 1, 0);
    tick(); #1 chunk("b2b_n3", 8'h04, 1, 1);
    tick(); #1 check("b2b_idle", m_valid, 0);

    // empty non-last beat is dropped, following single word goes out
    s_valid = 1; s_data = 32'h99999999; s_keep = 4'b0000; s_last = 0;
    tick(); #1;
    check("drop_m_valid", m_valid, 0);
    check("drop_s_ready", s_ready, 1);
    s_data = 32'h0000005A; s_keep = 4'b0001; s_last = 1;
    tick(); s_valid = 0; #1;
    chunk("single", 8'h5A, 1, 1);
    tick(); #1 check("single_idle", m_valid, 0);

    // empty last beat gives one keep-less last chunk
    s_valid = 1; s_data = 32'h12345678; s_keep = 4'b0000; s_last = 1;
    tick(); s_valid = 0; #1;
    chunk("zlast", 8'h78, 0, 1);
    tick(); #1 check("zlast_idle", m_valid, 0);

    // reset mid-packet
    s_valid = 1; s_data = 32'h88776655; s_keep = 4'b1111; s_last = 1;
    tick(); s_valid = 0; #1;
    chunk("mid_c0", 8'h55, 1, 0);
    tick(); #1 chunk("mid_c1", 8'h66, 1, 0);
    rst = 1; #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_data",  m_data, 0);
    check("mid_rst_s_ready", s_ready, 1);
    tick(); rst = 0;
    tick();
    s_valid = 1; s_data = 32'h0D0C0B0A; s_keep = 4'b1111; s_last = 1;
    tick(); s_valid = 0; #1;
    chunk("post_c0", 8'h0A, 1, 0);
    tick(); #1 chunk("post_c1", 8'h0B, 1, 0);
    tick(); #1 chunk("post_c2", 8'h0C, 1, 0);
    tick(); #1 chunk("post_c3", 8'h0D, 1, 1);
    tick(); #1 check("post_idle", m_valid, 0);

    // random packets against a throttled sink
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(100, 1);
      for (int unsigned w = 0; w < n; w++) begin
        ew = 8'($urandom_range(255));
        exp_w.push_back(ew);
        exp_l.push_back(w == n - 1);
        if (w % 4 == 0) begin
          d = '0;
          k = '0;
        end
        d[(w%4)*8 +: 8] = ew;
        k[w%4] = 1'b1;
        if ((w % 4 == 3) || (w == n - 1)) begin
          bd.push_back(d);
          bk.push_back(k);
          bl.push_back(w == n - 1);
        end
      end
    end
    pkts = 0;
    bi = 0;
    cyc = 0;
    while (((bi < bd.size()) || (exp_w.size() != 0)) && (cyc < 60000)) begin
      if (bi < bd.size()) begin
        s_valid = 1; s_data = bd[bi]; s_keep = bk[bi]; s_last = bl[bi];
      end else begin
        s_valid = 0;
      end
      m_ready = ($urandom_range(99) < 10);
      #1;
      if (m_valid && m_ready) begin
        if (m_keep[0]) begin
          if (exp_w.size() == 0) begin
            check("rand_extra", m_valid, 0);
          end else begin
            ew = exp_w.pop_front();
            el = exp_l.pop_front();
            check("rand_data", m_data, ew);
            check("rand_last", m_last, el);
          end
        end
        if (m_last) pkts++;
      end
      if (s_valid && s_ready) bi++;
      tick();
      cyc++;
    end
    s_valid = 0;
    check("rand_timeout", (cyc < 60000), 1);
    check("rand_pkts", pkts, 20);
    check("rand_left", exp_w.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
